camera_pixel_capture: RTL

//  Front end of the image path. Receives OV7670 RGB565 bytes (PCLK/HREF/VSYNC) and packs byte pairs into RGB332 pixels.

---
 rtl/camera_pixel_capture.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/camera_pixel_capture.sv
// OV7670 RGB565 byte-pair capture into RGB332 frame-buffer writes with X/Y clipping.
// Define TEST_PATTERN_EN to replace camera pixels with three colour bars of BAR_HEIGHT lines.
module camera_pixel_capture #(
  parameter int SCREEN_WIDTH  = 176,
  parameter int SCREEN_HEIGHT = 144
`ifdef TEST_PATTERN_EN
  , parameter int BAR_HEIGHT  = 48
`endif
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       CAM_PCLK,
  input  logic       CAM_HREF,
  input  logic       CAM_VSYNC,
  input  logic [7:0] CAM_DATA,
  output logic [7:0] PIXEL_OUT,
  output logic       W_EN,
  output logic [9:0] X_ADDR,
  output logic [9:0] Y_ADDR,
  output logic       FRAME_DONE,
  output logic       LINE_OVF
);

  localparam logic [9:0] W_LIM = 10'(SCREEN_WIDTH);
  localparam logic [9:0] H_LIM = 10'(SCREEN_HEIGHT);

  typedef enum logic [1:0] {
    WAIT_FRAME = 2'd0,
    WAIT_HREF  = 2'd1,
    CAPTURE    = 2'd2
  } state_t;

  state_t state, state_nxt;

  // [0] and [1] form the synchroniser, [2] is the history flop for edge detection.
  logic [2:0] pclk_sr, href_sr, vsync_sr;
  logic [7:0] data_s1, data_s2;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      pclk_sr  <= '0;
      href_sr  <= '0;
      vsync_sr <= '0;
      data_s1  <= '0;
      data_s2  <= '0;
    end else begin
      pclk_sr  <= {pclk_sr[1:0], CAM_PCLK};
      href_sr  <= {href_sr[1:0], CAM_HREF};
      vsync_sr <= {vsync_sr[1:0], CAM_VSYNC};
      data_s1  <= CAM_DATA;
      data_s2  <= data_s1;
    end
  end

  logic href_lvl, pclk_rise, href_fall, vsync_rise, vsync_fall;
  assign href_lvl   = href_sr[1];
  assign pclk_rise  = pclk_sr[1] & ~pclk_sr[2];
  assign href_fall  = href_sr[2] & ~href_sr[1];
  assign vsync_rise = vsync_sr[1] & ~vsync_sr[2];
  assign vsync_fall = vsync_sr[2] & ~vsync_sr[1];

  logic [9:0] x_cnt, y_cnt, x_cnt_nxt, y_cnt_nxt;
  logic       phase, phase_nxt;
  logic [5:0] hi_bits, hi_bits_nxt;
  logic       line_seen, line_seen_nxt;
  logic [7:0] pixel_nxt, pix_new;
  logic       w_en_nxt, frame_done_nxt, line_ovf_nxt;
  logic [9:0] x_addr_nxt, y_addr_nxt;

`ifdef TEST_PATTERN_EN
  always_comb begin
    if (y_cnt < 10'(BAR_HEIGHT))          pix_new = 8'hE0;
    else if (y_cnt < 10'(2 * BAR_HEIGHT)) pix_new = 8'h1C;
    else                                  pix_new = 8'h03;
  end
`else
  assign pix_new = {hi_bits, data_s2[4:3]};
`endif

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state <= WAIT_FRAME;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (vsync_rise) begin
      state_nxt = WAIT_FRAME;
    end else begin
      case (state)
        WAIT_FRAME: if (vsync_fall)            state_nxt = WAIT_HREF;
        WAIT_HREF:  if (pclk_rise && href_lvl) state_nxt = CAPTURE;
        CAPTURE:    if (href_fall)             state_nxt = WAIT_HREF;
        default:                               state_nxt = WAIT_FRAME;
      endcase
    end
  end

  // Event priority: VSYNC rise, then HREF fall, then PCLK rise.
  always_comb begin
    x_cnt_nxt      = x_cnt;
    y_cnt_nxt      = y_cnt;
    phase_nxt      = phase;
    hi_bits_nxt    = hi_bits;
    line_seen_nxt  = line_seen;
    pixel_nxt      = PIXEL_OUT;
    x_addr_nxt     = X_ADDR;
    y_addr_nxt     = Y_ADDR;
    w_en_nxt       = 1'b0;
    frame_done_nxt = 1'b0;
    line_ovf_nxt   = LINE_OVF;
    if (vsync_rise) begin
      frame_done_nxt = line_seen;
      line_seen_nxt  = 1'b0;
      phase_nxt      = 1'b0;
    end else begin
      case (state)
        WAIT_FRAME: begin
          if (vsync_fall) begin
            x_cnt_nxt     = '0;
            y_cnt_nxt     = '0;
            line_ovf_nxt  = 1'b0;
            line_seen_nxt = 1'b0;
            phase_nxt     = 1'b0;
          end
        end
        WAIT_HREF: begin
          if (pclk_rise && href_lvl) begin
            hi_bits_nxt = {data_s2[7:5], data_s2[2:0]};
            phase_nxt   = 1'b1;
          end
        end
        CAPTURE: begin
          if (href_fall) begin
            if (y_cnt < H_LIM) y_cnt_nxt = y_cnt + 10'd1;
            x_cnt_nxt     = '0;
            phase_nxt     = 1'b0;
            line_seen_nxt = 1'b1;
          end else if (pclk_rise && href_lvl) begin
            if (!phase) begin
              hi_bits_nxt = {data_s2[7:5], data_s2[2:0]};
              phase_nxt   = 1'b1;
            end else begin
              phase_nxt = 1'b0;
              if (x_cnt < W_LIM && y_cnt < H_LIM) begin
                w_en_nxt   = 1'b1;
                pixel_nxt  = pix_new;
                x_addr_nxt = x_cnt;
                y_addr_nxt = y_cnt;
              end else begin
                line_ovf_nxt = 1'b1;
              end
              if (x_cnt < W_LIM) x_cnt_nxt = x_cnt + 10'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      x_cnt      <= '0;
      y_cnt      <= '0;
      phase      <= 1'b0;
      hi_bits    <= '0;
      line_seen  <= 1'b0;
      PIXEL_OUT  <= '0;
      W_EN       <= 1'b0;
      X_ADDR     <= '0;
      Y_ADDR     <= '0;
      FRAME_DONE <= 1'b0;
      LINE_OVF   <= 1'b0;
    end else begin
      x_cnt      <= x_cnt_nxt;
      y_cnt      <= y_cnt_nxt;
      phase      <= phase_nxt;
      hi_bits    <= hi_bits_nxt;
      line_seen  <= line_seen_nxt;
      PIXEL_OUT  <= pixel_nxt;
      W_EN       <= w_en_nxt;
      X_ADDR     <= x_addr_nxt;
      Y_ADDR     <= y_addr_nxt;
      FRAME_DONE <= frame_done_nxt;
      LINE_OVF   <= line_ovf_nxt;
    end
  end

endmodule
